// File: rtl/ppu_pkg.sv
// Shared PPU types and timing constants.
// Contents:
//   sprite_eval_state_t  - sprite evaluation FSM states
//   dot constants        - CLEAR_END, EVAL_START, EVAL_END, OAMADDR_CLR_START/END
//   line constants       - LAST_VISIBLE, PRERENDER
//   sizing constants     - SEC_OAM_BYTES, MAX_SPRITES, SEC_OAM_FILL
package ppu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StEvalY,
        StEvalCopy,
        StEvalOvf,
        StDone
    } sprite_eval_state_t;

    localparam logic [8:0] CLEAR_END         = 9'd64;
    localparam logic [8:0] EVAL_START        = 9'd65;
    localparam logic [8:0] EVAL_END          = 9'd256;
    localparam logic [8:0] OAMADDR_CLR_START = 9'd257;
    localparam logic [8:0] OAMADDR_CLR_END   = 9'd320;

    localparam logic [8:0] LAST_VISIBLE      = 9'd239;
    localparam logic [8:0] PRERENDER         = 9'd261;

    localparam logic [5:0] SEC_OAM_BYTES     = 6'd32;
    localparam logic [3:0] MAX_SPRITES       = 4'd8;
    localparam logic [7:0] SEC_OAM_FILL      = 8'hFF;

endpackage

// File: rtl/ppu_sprite_range_cmp.sv
// Sprite vertical in-range test.
// Ports:
//   y        in  8 : sprite Y byte from OAM
//   scanline in  8 : low byte of the current scanline
//   height   in  5 : sprite height, 8 or 16
//   in_range out 1 : scanline falls within [y, y + height)
module ppu_sprite_range_cmp
    import ppu_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] scanline,
    input  logic [4:0] height,
    output logic       in_range
);

    logic [8:0] diff;

    // 9-bit unsigned difference: scanlines above the sprite wrap to a large value.
    always_comb begin
        diff     = {1'b0, scanline} - {1'b0, y};
        in_range = diff < {4'b0, height};
    end

endmodule

// File: rtl/ppu_sprite_eval.sv
// Sprite evaluation engine: clears secondary OAM, scans primary OAM for sprites on
// the current line, copies up to eight of them, and flags overflow (with the 2C02
// diagonal-scan behaviour).
// Ports:
//   clk, rst_n           : dot clock, async active-low reset
//   rendering_en         : BG or sprite rendering enabled
//   sprite_16            : 8x16 sprite mode
//   scanline, dot        : current raster position
//   oamaddr_in           : OAMADDR, sampled as the scan start
//   oam_raddr/oam_rdata  : primary OAM read port (async read)
//   sec_oam_*            : secondary OAM write port
//   oamaddr_clear        : force OAMADDR to 0 during sprite fetches
//   sprite_overflow_set  : one-dot pulse setting PPUSTATUS overflow
//   sprite_count         : sprites found for the next line
//   sprite0_next         : sprite 0 sits in secondary slot 0 for the next line
module ppu_sprite_eval
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rendering_en,
    input  logic       sprite_16,
    input  logic [8:0] scanline,
    input  logic [8:0] dot,
    input  logic [7:0] oamaddr_in,
    output logic [7:0] oam_raddr,
    input  logic [7:0] oam_rdata,
    output logic [4:0] sec_oam_waddr,
    output logic [7:0] sec_oam_wdata,
    output logic       sec_oam_we,
    output logic       oamaddr_clear,
    output logic       sprite_overflow_set,
    output logic [3:0] sprite_count,
    output logic       sprite0_next
);

    localparam logic [4:0] PTR_MAX = 5'(SEC_OAM_BYTES - 6'd1);

    sprite_eval_state_t state_q;
    logic [5:0] n_q;
    logic [1:0] m_q;
    logic [3:0] cnt_q;
    logic [4:0] ptr_q;
    logic       spr0_q;
    logic       first_q;
    logic [7:0] byte_q;

    logic       odd_dot;
    logic       eval_line;
    logic       in_eval;
    logic       in_range;
    logic       n_wrap;
    logic [4:0] ptr_inc;
    logic [4:0] height;

    assign odd_dot   = dot[0];
    assign eval_line = scanline <= LAST_VISIBLE;
    assign in_eval   = (state_q == StEvalY) || (state_q == StEvalCopy) || (state_q == StEvalOvf);
    assign n_wrap    = n_q == 6'd63;
    assign ptr_inc   = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + 5'd1;
    assign height    = sprite_16 ? 5'd16 : 5'd8;
    assign oam_raddr = {n_q, m_q};

    ppu_sprite_range_cmp u_range_cmp (
        .y        (byte_q),
        .scanline (scanline[7:0]),
        .height   (height),
        .in_range (in_range)
    );

    always_comb begin
        sec_oam_we    = 1'b0;
        sec_oam_waddr = '0;
        sec_oam_wdata = SEC_OAM_FILL;
        case (state_q)
            StClear: begin
                if (!odd_dot && dot >= 9'd2 && dot <= CLEAR_END) begin
                    sec_oam_we    = 1'b1;
                    sec_oam_waddr = 5'(dot[6:1] - 6'd1);
                end
            end
            StEvalY, StEvalCopy: begin
                // Y bytes are only stored for sprites that are actually in range.
                if (!odd_dot && (state_q == StEvalCopy || in_range)) begin
                    sec_oam_we    = 1'b1;
                    sec_oam_waddr = ptr_q;
                    sec_oam_wdata = byte_q;
                end
            end
            default: ;
        endcase
        sec_oam_we = sec_oam_we & rendering_en;

        sprite_overflow_set = rendering_en && state_q == StEvalOvf && !odd_dot && in_range;
        oamaddr_clear       = rendering_en && dot >= OAMADDR_CLR_START
                              && dot <= OAMADDR_CLR_END && (eval_line || scanline == PRERENDER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            n_q          <= '0;
            m_q          <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            spr0_q       <= 1'b0;
            first_q      <= 1'b0;
            byte_q       <= SEC_OAM_FILL;
            sprite_count <= '0;
            sprite0_next <= 1'b0;
        end else begin
            if (rendering_en && eval_line && dot == OAMADDR_CLR_START) begin
                sprite_count <= cnt_q;
                sprite0_next <= spr0_q;
            end

            if (in_eval && odd_dot) begin
                byte_q <= oam_rdata;
            end

            if (!rendering_en) begin
                state_q <= StIdle;
            end else if ((in_eval || state_q == StDone) && dot > EVAL_END) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (dot == 9'd0 && eval_line) begin
                            state_q <= StClear;
                        end
                    end
                    StClear: begin
                        // Load on the last clear dot so the scan address is live at dot 65.
                        if (dot == EVAL_START - 9'd1) begin
                            n_q     <= oamaddr_in[7:2];
                            m_q     <= oamaddr_in[1:0];
                            cnt_q   <= '0;
                            ptr_q   <= '0;
                            spr0_q  <= 1'b0;
                            first_q <= 1'b1;
                            state_q <= StEvalY;
                        end
                    end
                    StEvalY: begin
                        if (!odd_dot) begin
                            first_q <= 1'b0;
                            if (in_range) begin
                                ptr_q   <= ptr_inc;
                                m_q     <= 2'd1;
                                state_q <= StEvalCopy;
                                if (first_q) begin
                                    spr0_q <= 1'b1;
                                end
                            end else begin
                                n_q <= n_q + 6'd1;
                                if (n_wrap) begin
                                    state_q <= StDone;
                                end
                            end
                        end
                    end
                    StEvalCopy: begin
                        if (!odd_dot) begin
                            ptr_q <= ptr_inc;
                            if (m_q == 2'd3) begin
                                m_q   <= 2'd0;
                                n_q   <= n_q + 6'd1;
                                cnt_q <= cnt_q + 4'd1;
                                if (n_wrap) begin
                                    state_q <= StDone;
                                end else if (cnt_q == MAX_SPRITES - 4'd1) begin
                                    state_q <= StEvalOvf;
                                end else begin
                                    state_q <= StEvalY;
                                end
                            end else begin
                                m_q <= m_q + 2'd1;
                            end
                        end
                    end
                    StEvalOvf: begin
                        // m advances alongside n without carrying: the diagonal-scan bug.
                        if (!odd_dot) begin
                            if (in_range) begin
                                state_q <= StDone;
                            end else begin
                                n_q <= n_q + 6'd1;
                                m_q <= m_q + 2'd1;
                                if (n_wrap) begin
                                    state_q <= StDone;
                                end
                            end
                        end
                    end
                    StDone: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_sprite_eval.sv
// Randomised and directed line-by-line check of ppu_sprite_eval against a per-line
// behavioural model of sprite evaluation.
module tb_ppu_sprite_eval;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rendering_en = 1'b0;
    logic       sprite_16 = 1'b0;
    logic [8:0] scanline = '0;
    logic [8:0] dot = '0;
    logic [7:0] oamaddr_in = '0;
    logic [7:0] oam_raddr;
    logic [7:0] oam_rdata;
    logic [4:0] sec_oam_waddr;
    logic [7:0] sec_oam_wdata;
    logic       sec_oam_we;
    logic       oamaddr_clear;
    logic       sprite_overflow_set;
    logic [3:0] sprite_count;
    logic       sprite0_next;

    logic [7:0] oam [256];

    int n_checks = 0;
    int n_pass = 0;

    // Expected per-dot behaviour for the line being run.
    bit exp_we [341];
    int exp_addr [341];
    int exp_data [341];
    bit exp_ovf [341];
    int line_cnt;
    bit line_s0;
    // Expected registered outputs as currently visible.
    int cur_cnt = 0;
    bit cur_s0 = 1'b0;

    always #5 clk = ~clk;

    assign oam_rdata = oam[oam_raddr];

    ppu_sprite_eval dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rendering_en        (rendering_en),
        .sprite_16           (sprite_16),
        .scanline            (scanline),
        .dot                 (dot),
        .oamaddr_in          (oamaddr_in),
        .oam_raddr           (oam_raddr),
        .oam_rdata           (oam_rdata),
        .sec_oam_waddr       (sec_oam_waddr),
        .sec_oam_wdata       (sec_oam_wdata),
        .sec_oam_we          (sec_oam_we),
        .oamaddr_clear       (oamaddr_clear),
        .sprite_overflow_set (sprite_overflow_set),
        .sprite_count        (sprite_count),
        .sprite0_next        (sprite0_next)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // All Y bytes off-screen, other bytes random.
    task automatic fill_oam_blank();
        for (int i = 0; i < 256; i++) oam[i] = (i % 4 == 0) ? 8'hFF : 8'($urandom);
    endtask

    // Walks the evaluation rules one OAM byte per read/act dot pair.
    task automatic build_model(input int s, input bit h16, input int oa, input bit en);
        int n, m, cnt, ptr, mode, b, diff, h;
        bit first, inr, s0;
        for (int d = 0; d < 341; d++) begin
            exp_we[d] = 1'b0; exp_addr[d] = 0; exp_data[d] = 0; exp_ovf[d] = 1'b0;
        end
        line_cnt = 0;
        line_s0 = 1'b0;
        if (!en || s > 239) return;
        for (int k = 1; k <= 32; k++) begin
            exp_we[2 * k] = 1'b1; exp_addr[2 * k] = k - 1; exp_data[2 * k] = 8'hFF;
        end
        h = h16 ? 16 : 8;
        n = oa / 4; m = oa % 4; cnt = 0; ptr = 0; first = 1'b1; s0 = 1'b0;
        mode = 0;  // 0 search Y, 1 copy, 2 overflow scan, 3 done
        for (int d = 66; d <= 256 && mode != 3; d += 2) begin
            b = int'(oam[n * 4 + m]);
            diff = s - b;
            inr = (diff >= 0) && (diff < h);
            case (mode)
                0: begin
                    if (inr) begin
                        exp_we[d] = 1'b1; exp_addr[d] = ptr; exp_data[d] = b;
                        ptr++; m = 1; mode = 1;
                        if (first) s0 = 1'b1;
                    end else begin
                        n++;
                        if (n == 64) mode = 3;
                    end
                    first = 1'b0;
                end
                1: begin
                    exp_we[d] = 1'b1; exp_addr[d] = ptr; exp_data[d] = b;
                    ptr++;
                    if (m == 3) begin
                        m = 0; n++; cnt++;
                        if (n == 64) mode = 3;
                        else if (cnt == 8) mode = 2;
                        else mode = 0;
                    end else m++;
                end
                default: begin
                    if (inr) begin
                        exp_ovf[d] = 1'b1; mode = 3;
                    end else begin
                        n++; m = (m + 1) % 4;
                        if (n == 64) mode = 3;
                    end
                end
            endcase
        end
        line_cnt = cnt;
        line_s0 = s0;
    endtask

    task automatic run_line(input int s, input bit h16, input int oa, input bit en,
                            input int rst_at, input int rst_rel);
        bit exp_clr;
        build_model(s, h16, oa, en);
        if (rst_at >= 0) begin
            for (int d = rst_at; d < 341; d++) begin
                exp_we[d] = 1'b0; exp_ovf[d] = 1'b0;
            end
            line_cnt = 0;
            line_s0 = 1'b0;
        end
        for (int d = 0; d <= 340; d++) begin
            dot = 9'(d); scanline = 9'(s); sprite_16 = h16; oamaddr_in = 8'(oa);
            rendering_en = en;
            if (d == rst_at) begin
                rst_n = 1'b0; cur_cnt = 0; cur_s0 = 1'b0;
            end
            if (d == rst_rel) rst_n = 1'b1;
            if (d == 258 && en && s <= 239) begin
                cur_cnt = line_cnt; cur_s0 = line_s0;
            end
            @(negedge clk);
            check($sformatf("we L%0d d%0d", s, d), int'(sec_oam_we), int'(exp_we[d]));
            if (exp_we[d]) begin
                check($sformatf("waddr L%0d d%0d", s, d), int'(sec_oam_waddr), exp_addr[d]);
                check($sformatf("wdata L%0d d%0d", s, d), int'(sec_oam_wdata), exp_data[d]);
            end
            check($sformatf("ovf L%0d d%0d", s, d), int'(sprite_overflow_set), int'(exp_ovf[d]));
            exp_clr = en && d >= 257 && d <= 320 && (s <= 239 || s == 261);
            check($sformatf("oamclr L%0d d%0d", s, d), int'(oamaddr_clear), int'(exp_clr));
            if (d == 0 || d == 257 || d == 258 || d == 340) begin
                check($sformatf("count L%0d d%0d", s, d), int'(sprite_count), cur_cnt);
                check($sformatf("spr0 L%0d d%0d", s, d), int'(sprite0_next), int'(cur_s0));
            end
            if (rst_at >= 0 && d == rst_at + 20) begin
                check("rst waddr", int'(sec_oam_waddr), 0);
                check("rst wdata", int'(sec_oam_wdata), 8'hFF);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int s, oa;
        bit h16;
        fill_oam_blank();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset count", int'(sprite_count), 0);
        check("reset spr0", int'(sprite0_next), 0);
        check("reset we", int'(sec_oam_we), 0);
        check("reset waddr", int'(sec_oam_waddr), 0);
        check("reset wdata", int'(sec_oam_wdata), 8'hFF);
        check("reset ovf", int'(sprite_overflow_set), 0);
        check("reset oamclr", int'(oamaddr_clear), 0);
        check("reset raddr", int'(oam_raddr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nothing in range: only the 32 clear writes.
        run_line(10, 1'b0, 0, 1'b1, -1, -1);

        // Sprites 3 and 7 on line 12.
        fill_oam_blank();
        oam[12] = 8'd10; oam[28] = 8'd10;
        run_line(12, 1'b0, 0, 1'b1, -1, -1);

        // Scan starts at sprite 2 via OAMADDR, which then counts as "sprite 0".
        fill_oam_blank();
        oam[8] = 8'd30;
        run_line(30, 1'b0, 8'h08, 1'b1, -1, -1);

        // Nine sprites in range: genuine overflow.
        fill_oam_blank();
        for (int i = 0; i < 9; i++) oam[i * 4] = 8'd20;
        run_line(20, 1'b0, 0, 1'b1, -1, -1);

        // Eight in range, then a false overflow hit on sprite 9's tile byte.
        fill_oam_blank();
        for (int i = 0; i < 8; i++) oam[i * 4] = 8'd100;
        oam[37] = 8'd100;
        run_line(100, 1'b0, 0, 1'b1, -1, -1);

        // Height boundaries in both sprite sizes.
        fill_oam_blank();
        oam[0] = 8'd25; oam[4] = 8'd24; oam[8] = 8'd33; oam[12] = 8'd32; oam[16] = 8'd41;
        run_line(40, 1'b1, 0, 1'b1, -1, -1);
        run_line(40, 1'b0, 0, 1'b1, -1, -1);

        // Pre-render, first post-render, and rendering-disabled lines.
        run_line(261, 1'b0, 0, 1'b1, -1, -1);
        run_line(240, 1'b0, 0, 1'b1, -1, -1);
        run_line(40, 1'b0, 0, 1'b0, -1, -1);

        // Reset in the middle of copying, then a clean line.
        fill_oam_blank();
        for (int i = 4; i < 12; i++) oam[i * 4] = 8'd48;
        run_line(50, 1'b0, 0, 1'b1, 100, 150);
        run_line(50, 1'b0, 0, 1'b1, -1, -1);

        // Random lines.
        for (int t = 0; t < 14; t++) begin
            s = int'($urandom_range(0, 239));
            h16 = 1'($urandom_range(0, 1));
            oa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0;
            for (int i = 0; i < 256; i++) begin
                if (i % 4 == 0 && $urandom_range(0, 2) != 0)
                    oam[i] = 8'((s - int'($urandom_range(0, 18))) & 255);
                else
                    oam[i] = 8'($urandom);
            end
            run_line(s, h16, oa, 1'b1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
